// File: rtl/router_ctrl_fsm_if.sv
// Purpose : control-plane signal bundle between the router datapath/FIFOs and the control FSM.
// Latency : n/a (wires only).
// Backpressure: busy (slave -> master) tells the source to hold data_in; read enables come from the destinations.
// Modports: master = datapath/FIFO side (drives status), slave = control FSM (drives strobes and soft resets).
interface router_ctrl_fsm_if;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       valid_out_0;
   logic       valid_out_1;
   logic       valid_out_2;
   logic       read_enb_0;
   logic       read_enb_1;
   logic       read_enb_2;
   logic       busy;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       write_enb_reg;
   logic       rst_int_reg;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
             parity_done, low_pkt_valid, valid_out_0, valid_out_1, valid_out_2,
             read_enb_0, read_enb_1, read_enb_2,
      input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, soft_reset_0, soft_reset_1, soft_reset_2
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
             parity_done, low_pkt_valid, valid_out_0, valid_out_1, valid_out_2,
             read_enb_0, read_enb_1, read_enb_2,
      output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, soft_reset_0, soft_reset_1, soft_reset_2
   );
endinterface

// File: rtl/router_ctrl_fsm.sv
// Purpose : 1x3 router control FSM (header decode, header/payload/parity load sequencing) plus per-port read-timeout timers.
// Latency : state outputs are Moore (one cycle after the deciding input); soft_reset_x is a registered one-cycle pulse.
// Backpressure: busy holds the source; the FSM waits on fifo_full / empty flags; unread FIFOs are flushed after TIMEOUT cycles.
// Ports: clock, reset (async active-high), bus (router_ctrl_fsm_if.slave) carrying all status inputs and control outputs.
module router_ctrl_fsm #(
   parameter int TIMEOUT = 30
) (
   input logic               clock,
   input logic               reset,
   router_ctrl_fsm_if.slave  bus
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    addr_q;
   logic [2:0]    sr_q;
   logic [CW-1:0] cnt_q [3];

   // Padded to four entries so the 2-bit address can index them directly;
   // address 3 never selects a real port.
   logic [3:0] empty_v;
   logic [3:0] sr_v;
   logic [2:0] vo_v;
   logic [2:0] re_v;

   assign empty_v = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
   assign sr_v    = {1'b0, sr_q};
   assign vo_v    = {bus.valid_out_2, bus.valid_out_1, bus.valid_out_0};
   assign re_v    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

   logic hdr_ok;
   assign hdr_ok = bus.pkt_valid && (bus.data_in != 2'd3);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE_ADDRESS && hdr_ok)
            addr_q <= bus.data_in;
      end
   end

   always_comb begin
      state_d           = state_q;
      bus.busy          = 1'b0;
      bus.detect_add    = 1'b0;
      bus.lfd_state     = 1'b0;
      bus.ld_state      = 1'b0;
      bus.laf_state     = 1'b0;
      bus.full_state    = 1'b0;
      bus.write_enb_reg = 1'b0;
      bus.rst_int_reg   = 1'b0;

      case (state_q)
         DECODE_ADDRESS: begin
            bus.detect_add = 1'b1;
            // A header to port 3 or without pkt_valid is silently dropped.
            if (hdr_ok)
               state_d = empty_v[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         LOAD_FIRST_DATA: begin
            bus.lfd_state = 1'b1;
            bus.busy      = 1'b1;
            state_d       = LOAD_DATA;
         end
         LOAD_DATA: begin
            bus.ld_state      = 1'b1;
            bus.write_enb_reg = 1'b1;
            if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!bus.pkt_valid) state_d = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            bus.full_state = 1'b1;
            bus.busy       = 1'b1;
            if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            bus.laf_state     = 1'b1;
            bus.write_enb_reg = 1'b1;
            bus.busy          = 1'b1;
            if (bus.parity_done)        state_d = DECODE_ADDRESS;
            else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
            else                        state_d = LOAD_DATA;
         end
         LOAD_PARITY: begin
            bus.write_enb_reg = 1'b1;
            bus.busy          = 1'b1;
            state_d           = CHECK_PARITY_ERROR;
         end
         CHECK_PARITY_ERROR: begin
            bus.rst_int_reg = 1'b1;
            bus.busy        = 1'b1;
            state_d         = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY: begin
            bus.busy = 1'b1;
            if (empty_v[addr_q]) state_d = LOAD_FIRST_DATA;
         end
         default: state_d = DECODE_ADDRESS;
      endcase

      // A flush of the FIFO we are feeding abandons the packet.
      if (state_q != DECODE_ADDRESS && sr_v[addr_q])
         state_d = DECODE_ADDRESS;
   end

   // Read-timeout timers: count consecutive unread cycles; wrap and pulse at TIMEOUT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr_q <= 3'b000;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (vo_v[i] && !re_v[i]) begin
               if (cnt_q[i] == LAST) begin
                  sr_q[i]  <= 1'b1;
                  cnt_q[i] <= '0;
               end else begin
                  sr_q[i]  <= 1'b0;
                  cnt_q[i] <= cnt_q[i] + CW'(1);
               end
            end else begin
               sr_q[i]  <= 1'b0;
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign bus.soft_reset_0 = sr_q[0];
   assign bus.soft_reset_1 = sr_q[1];
   assign bus.soft_reset_2 = sr_q[2];

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Purpose : self-checking bench for router_ctrl_fsm; directed scenarios plus randomized traffic against a behavioural model.
// Latency : model predicts outputs one clock after inputs are applied; sampled 1 ns after the rising edge.
// Backpressure: n/a (bench drives every input directly).
module tb_router_ctrl_fsm;
   localparam int TIMEOUT = 30;

   // Behavioural phases of a packet (names only; numbering is the bench's own).
   localparam int P_IDLE = 10, P_HDR = 11, P_BODY = 12, P_STALL = 13,
                  P_RESUME = 14, P_PAR = 15, P_CHK = 16, P_WAIT = 17;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   router_ctrl_fsm_if rif ();
   router_ctrl_fsm #(.TIMEOUT(TIMEOUT)) dut (.clock(clock), .reset(reset), .bus(rif));

   int n_cmp  = 0;
   int n_fail = 0;

   int m_phase;
   int m_addr;
   int m_run [3];
   logic [2:0] m_sr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
   function automatic logic [7:0] phase_outs(input int ph);
      case (ph)
         P_IDLE:   return 8'b0100_0000;
         P_HDR:    return 8'b1010_0000;
         P_BODY:   return 8'b0001_0010;
         P_STALL:  return 8'b1000_0100;
         P_RESUME: return 8'b1000_1010;
         P_PAR:    return 8'b1000_0010;
         P_CHK:    return 8'b1000_0001;
         P_WAIT:   return 8'b1000_0000;
         default:  return 8'hxx;
      endcase
   endfunction

   function automatic logic port_empty(input int p);
      case (p)
         0: return rif.fifo_empty_0;
         1: return rif.fifo_empty_1;
         2: return rif.fifo_empty_2;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] dut_outs();
      return {rif.busy, rif.detect_add, rif.lfd_state, rif.ld_state,
              rif.laf_state, rif.full_state, rif.write_enb_reg, rif.rst_int_reg};
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_addr  = 0;
      m_sr    = 3'b000;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, "_outs"}, 32'(dut_outs()), 32'(phase_outs(m_phase)));
      check_eq({tag, "_srst"}, 32'({rif.soft_reset_2, rif.soft_reset_1, rif.soft_reset_0}), 32'(m_sr));
   endtask

   // Advance one clock with the currently driven inputs; update model; compare.
   task automatic step(input string tag);
      int nxt;
      int naddr;
      int d;
      logic [2:0] vo, re, nsr;
      d     = int'(rif.data_in);
      naddr = m_addr;
      nxt   = m_phase;
      if (m_phase != P_IDLE && m_sr[m_addr]) begin
         nxt = P_IDLE;
      end else begin
         case (m_phase)
            P_IDLE:   if (rif.pkt_valid && d != 3) nxt = port_empty(d) ? P_HDR : P_WAIT;
            P_HDR:    nxt = P_BODY;
            P_BODY:   nxt = rif.fifo_full ? P_STALL : (!rif.pkt_valid ? P_PAR : P_BODY);
            P_STALL:  nxt = rif.fifo_full ? P_STALL : P_RESUME;
            P_RESUME: nxt = rif.parity_done ? P_IDLE : (rif.low_pkt_valid ? P_PAR : P_BODY);
            P_PAR:    nxt = P_CHK;
            P_CHK:    nxt = rif.fifo_full ? P_STALL : P_IDLE;
            P_WAIT:   nxt = port_empty(m_addr) ? P_HDR : P_WAIT;
            default:  nxt = P_IDLE;
         endcase
      end
      if (m_phase == P_IDLE && rif.pkt_valid && d != 3) naddr = d;
      vo = {rif.valid_out_2, rif.valid_out_1, rif.valid_out_0};
      re = {rif.read_enb_2, rif.read_enb_1, rif.read_enb_0};
      for (int i = 0; i < 3; i++) begin
         // Pulse whenever the unbroken unread run reaches a multiple of TIMEOUT.
         if (vo[i] && !re[i]) begin
            m_run[i]++;
            nsr[i] = (m_run[i] % TIMEOUT) == 0;
         end else begin
            m_run[i] = 0;
            nsr[i]   = 1'b0;
         end
      end
      @(posedge clock);
      #1;
      m_phase = nxt;
      m_addr  = naddr;
      m_sr    = nsr;
      compare_all(tag);
   endtask

   task automatic clear_inputs();
      rif.pkt_valid = 0; rif.data_in = 0; rif.fifo_full = 0;
      rif.fifo_empty_0 = 1; rif.fifo_empty_1 = 1; rif.fifo_empty_2 = 1;
      rif.parity_done = 0; rif.low_pkt_valid = 0;
      rif.valid_out_0 = 0; rif.valid_out_1 = 0; rif.valid_out_2 = 0;
      rif.read_enb_0 = 0; rif.read_enb_1 = 0; rif.read_enb_2 = 0;
   endtask

   // Assert reset between edges, check the immediate effect, hold over one edge, release.
   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all({tag, "_async"});
      @(posedge clock);
      #1;
      compare_all({tag, "_held"});
      reset = 1'b0;
   endtask

   initial begin
      int first;
      clear_inputs();
      model_reset();
      #1;
      compare_all("reset");
      @(posedge clock);
      #1;
      reset = 1'b0;
      compare_all("reset_rel");

      // Normal packet to port 1: header, 3 payload, then pkt_valid low.
      rif.pkt_valid = 1; rif.data_in = 2'd1;
      step("pkt_hdr");
      rif.data_in = 2'd2;                // payload bits, not an address
      step("pkt_lfd");
      step("pkt_ld1");
      step("pkt_ld2");
      rif.pkt_valid = 0;
      step("pkt_ld3");
      step("pkt_lp");
      step("pkt_cpe");
      check_eq("pkt_back_da", 32'(rif.detect_add), 32'd1);

      // FIFO full for 4 cycles in LOAD_DATA, low_pkt_valid at release.
      rif.pkt_valid = 1; rif.data_in = 2'd0;
      step("full_hdr"); step("full_lfd");
      rif.fifo_full = 1;
      for (int i = 0; i < 4; i++) step("full_ffs");
      check_eq("full_no_wen", 32'(rif.write_enb_reg), 32'd0);
      rif.fifo_full = 0; rif.pkt_valid = 0;
      step("full_release");
      rif.low_pkt_valid = 1;
      step("full_laf");
      rif.low_pkt_valid = 0;
      step("full_lp"); step("full_cpe");

      // Header to non-empty port 2 waits, then proceeds once empty.
      rif.fifo_empty_2 = 0; rif.pkt_valid = 1; rif.data_in = 2'd2;
      step("wte_hdr");
      rif.data_in = 2'd0;
      for (int i = 0; i < 4; i++) step("wte_wait");
      check_eq("wte_busy", 32'(rif.busy), 32'd1);
      rif.fifo_empty_2 = 1;
      step("wte_go");
      check_eq("wte_lfd", 32'(rif.lfd_state), 32'd1);
      async_reset("wte");

      // Invalid header address 3 is dropped.
      rif.pkt_valid = 1; rif.data_in = 2'd3;
      step("bad_hdr"); step("bad_hdr2");
      check_eq("bad_busy", 32'(rif.busy), 32'd0);
      rif.pkt_valid = 0;

      // Exact timeout cycle on port 0.
      rif.valid_out_0 = 1;
      first = 0;
      for (int i = 1; i <= 40; i++) begin
         step("to_run");
         if (rif.soft_reset_0 && first == 0) first = i;
      end
      check_eq("to_cycle", 32'(first), 32'd30);
      // A read at cycle 20 restarts the count: pulse then lands at cycle 50.
      rif.valid_out_0 = 0; step("to_idle");
      rif.valid_out_0 = 1;
      first = 0;
      for (int i = 1; i <= 60; i++) begin
         rif.read_enb_0 = (i == 20);
         step("to_read");
         if (rif.soft_reset_0 && first == 0) first = i;
      end
      check_eq("to_restart", 32'(first), 32'd50);
      clear_inputs();
      async_reset("to");

      // Soft reset of the active port aborts LOAD_DATA; another port's does not.
      rif.valid_out_0 = 1; rif.valid_out_1 = 1;
      for (int i = 0; i < 26; i++) step("sr_pre");
      rif.pkt_valid = 1; rif.data_in = 2'd0;
      step("sr_hdr"); step("sr_lfd"); step("sr_ld"); step("sr_pulse");
      check_eq("sr_pulse0", 32'(rif.soft_reset_0), 32'd1);
      step("sr_abort");
      check_eq("sr_to_da", 32'(rif.detect_add), 32'd1);
      clear_inputs();
      async_reset("sr");

      // Async reset in FIFO_FULL_STATE with a timer at 25.
      rif.valid_out_2 = 1;
      rif.pkt_valid = 1; rif.data_in = 2'd1;
      step("ar_hdr"); step("ar_lfd");
      rif.fifo_full = 1;
      for (int i = 0; i < 23; i++) step("ar_ffs");
      check_eq("ar_in_ffs", 32'(rif.full_state), 32'd1);
      async_reset("ar");
      check_eq("ar_da", 32'(rif.detect_add), 32'd1);
      rif.valid_out_2 = 0; rif.fifo_full = 0; rif.pkt_valid = 0;
      for (int i = 0; i < 10; i++) step("ar_after");

      // Randomized traffic with sticky per-port read behaviour so timeouts occur.
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) begin
            rif.valid_out_0 = ($urandom_range(0, 3) != 0);
            rif.valid_out_1 = ($urandom_range(0, 3) != 0);
            rif.valid_out_2 = ($urandom_range(0, 3) != 0);
         end
         rif.pkt_valid     = ($urandom_range(0, 9) < 7);
         rif.data_in       = 2'($urandom_range(0, 3));
         rif.fifo_full     = ($urandom_range(0, 4) == 0);
         rif.fifo_empty_0  = ($urandom_range(0, 4) < 3);
         rif.fifo_empty_1  = ($urandom_range(0, 4) < 3);
         rif.fifo_empty_2  = ($urandom_range(0, 4) < 3);
         rif.parity_done   = ($urandom_range(0, 4) == 0);
         rif.low_pkt_valid = ($urandom_range(0, 4) == 0);
         rif.read_enb_0    = ($urandom_range(0, 49) == 0);
         rif.read_enb_1    = ($urandom_range(0, 49) == 0);
         rif.read_enb_2    = ($urandom_range(0, 49) == 0);
         step("rand");
         if (c == 1500) async_reset("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
